mem_stage_dmem: RTL
===================

// Module: mem_stage_dmem
// PURPOSE
//  MEM-stage data memory of the 5-stage MIPS pipeline. Sits between EX/MEM and MEM/WB:
//  - Consumes the EX/MEM control bits and the ALU address/store data.
//  - Produces rdata_o, which MEM/WB captures as its read-data input.
//  - Models a variable-latency data RAM and drives stall_o, which freezes PC, IF/ID, ID/EX and EX/MEM while an access is in flight.
// PARAMETERS
//  DEPTH_WORDS  256  number of 32-bit words; power of 2; AW = $clog2(DEPTH_WORDS)
//  LAT          2    access latency in cycles, range 0..15; 0 = single-cycle memory, stall never asserted
// PORTS
//  clk_i        in   1   clock, rising edge
//  rst_i        in   1   reset, asynchronous, active-high
//  MemRead_i    in   1   load request (from EX/MEM M bits)
//  MemWrite_i   in   1   store request (from EX/MEM M bits)
//  addr_i       in   32  byte address (ALU output)
//  wdata_i      in   32  store data (rt value)
//  rdata_o      out  32  load data to MEM/WB
//  stall_o      out  1   hold upstream pipeline registers and PC
//  misalign_o   out  1   request active and addr_i[1:0] != 0 (combinational)
// BEHAVIOUR
//  - Reset (async, rst_i=1):
//      - State IDLE, cnt=0, rdata_q=0.
//      - Hence rdata_o=0, stall_o=0, misalign_o follows inputs.
//      - RAM contents are NOT reset.
//  - req = MemRead_i | MemWrite_i. Word index = addr_i[AW+1:2]; upper address bits are ignored (wrap modulo DEPTH_WORDS).
//  - Misaligned address: low 2 bits ignored; access proceeds on that word; misalign_o=1 only as a flag.
//  - FSM for LAT>=1, states IDLE / BUSY; cnt is 4 bits:
//      - IDLE, req=0: stall_o=0; stay IDLE.
//      - IDLE, req=1: stall_o=1 (combinational, same cycle). Next edge: latch op/addr/wdata; cnt<=LAT-1; go BUSY.
//      - BUSY, cnt!=0: stall_o=1; next edge cnt<=cnt-1.
//      - BUSY, cnt==0: stall_o=0; rdata_o valid; next edge go IDLE unconditionally. The still-present request is NOT re-triggered; upstream advances on this same edge.
//  - RAM commit: on the edge that enters BUSY with cnt==0. For LAT=1 that is the IDLE->BUSY edge.
//      - Read: rdata_q <= ram[idx].
//      - Write: ram[idx] <= wdata; rdata_q <= 0.
//  - Latency: one access occupies exactly LAT+1 cycles. stall_o is high for the first LAT cycles and low in the last.
//  - LAT=0: no FSM. rdata_o = ram[idx] combinationally when MemRead_i, else 0. Write commits at the edge; stall_o tied 0.
//  - MemRead_i and MemWrite_i both 1: treated as a write; rdata_o=0 for that access.
//  - rdata_o = rdata_q at all times for LAT>=1; holds the last value between accesses.
//  - Store then load to the same word, back to back: the load returns the new data (store committed earlier).
//  - Reset mid-operation (rst_i during BUSY before the commit edge): access aborted, RAM word unchanged, stall_o=0 immediately.
//  - A reset asserted after the commit edge leaves the write in place.
// STRUCTURE
//  - Shared package mips_pkg:
//      - State encoding localparams (S_IDLE=1'b0, S_BUSY=1'b1).
//      - Word-address slice helper constant WORD_LSB=2.
//      - M-bit indices of the EX/MEM control field (M_READ=1, M_WRITE=0).
//  - Sub-module dmem_ram: single-port synchronous RAM, DEPTH_WORDS x 32.
//      - Ports clk_i, we_i, re_i, idx_i[AW-1:0], wdata_i, rdata_o (registered).
//      - No reset.
//  - Top module: FSM, cnt, request latches, output mux.
// TESTING (DEPTH_WORDS=256, LAT=2 unless noted)
//  1. Reset: pulse rst_i mid-cycle -> rdata_o=0, stall_o=0 asynchronously.
//  2. Store 0xDEADBEEF @0x10 -> stall_o=1 for 2 cycles, then 0.
//     Then load @0x10 -> stall_o 1,1,0; rdata_o=0xDEADBEEF in the 3rd cycle.
//  3. Loads @0x0 then @0x4 (preloaded 0x11111111 / 0x22222222), inputs held while stalled
//     -> exactly 3 cycles each, correct data, no duplicate access.
//  4. Wrap: store 0xCAFEF00D @0x400 -> load @0x0 returns 0xCAFEF00D.
//     Misaligned load @0x13 -> misalign_o=1, returns word 4.
//  5. rst_i in the 1st BUSY cycle of store 0x12345678 @0x20 (old 0xAAAAAAAA)
//     -> stall_o=0 at once; a later load @0x20 returns 0xAAAAAAAA.
//  6. MemRead_i=MemWrite_i=1, store 0x5 @0x8 -> rdata_o=0, word 2=0x5.
//     LAT=0 build: load @0x8 -> rdata_o=0x5 same cycle, stall_o never 1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline slice:
// FSM encoding, word-address slicing and EX/MEM M-bit positions.
package mips_pkg;

  localparam logic S_IDLE = 1'b0;
  localparam logic S_BUSY = 1'b1;

  localparam int WORD_LSB = 2;

  localparam int M_READ  = 1;
  localparam int M_WRITE = 0;

  typedef logic [1:0] mbits_t;

endpackage

// File: rtl/mem_stage_dmem_ram.sv
// Single-port data RAM, DEPTH_WORDS x 32, no reset.
// Read port is registered unless COMB_RD selects a flow-through read.
module dmem_ram #(
  parameter int DEPTH_WORDS = 256,
  parameter bit COMB_RD     = 1'b0,
  localparam int AW         = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] idx_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];

  // Store port: write the addressed word on the clock edge
  always_ff @(posedge clk_i) begin
    if (we_i) mem[idx_i] <= wdata_i;
  end

  if (COMB_RD) begin : g_comb_rd
    assign rdata_o = re_i ? mem[idx_i] : 32'h0;
  end else begin : g_reg_rd
    logic [31:0] rq;
    // Load port: capture the addressed word, hold it otherwise
    always_ff @(posedge clk_i) begin
      if (re_i) rq <= mem[idx_i];
    end
    assign rdata_o = rq;
  end

endmodule

// File: rtl/mem_stage_dmem.sv
// MEM-stage data memory with configurable access latency.
// Stalls the upstream pipeline while an access is in flight.
module mem_stage_dmem
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LAT         = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        misalign_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  mbits_t        m_in;
  logic          req;
  logic [AW-1:0] idx_in;
  logic          unused_addr;

  assign m_in[M_READ]  = MemRead_i;
  assign m_in[M_WRITE] = MemWrite_i;
  assign req           = |m_in;
  assign idx_in        = addr_i[AW+WORD_LSB-1:WORD_LSB];
  assign unused_addr   = ^addr_i[31:AW+WORD_LSB];
  assign misalign_o    = req & (|addr_i[WORD_LSB-1:0]);

  if (LAT == 0) begin : g_comb
    logic we;
    logic re;

    assign we = m_in[M_WRITE] & ~rst_i;
    assign re = m_in[M_READ] & ~m_in[M_WRITE];

    dmem_ram #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .COMB_RD    (1'b1)
    ) u_ram (
      .clk_i  (clk_i),
      .we_i   (we),
      .re_i   (re),
      .idx_i  (idx_in),
      .wdata_i(wdata_i),
      .rdata_o(rdata_o)
    );

    assign stall_o = 1'b0;

  end else begin : g_fsm
    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);
    localparam bit         ONE_CYC  = (LAT == 1);

    logic          state;
    logic          state_nx;
    logic [3:0]    cnt;
    mbits_t        op_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic          sel_q;

    mbits_t        c_op;
    logic [AW-1:0] c_idx;
    logic [31:0]   c_wdata;
    logic          c_wr;
    logic          c_rd;
    logic          commit;
    logic [31:0]   ram_q;

    // Commit uses live inputs on the IDLE->BUSY edge, latched ones later
    assign c_op    = (state == S_IDLE) ? m_in : op_q;
    assign c_idx   = (state == S_IDLE) ? idx_in : idx_q;
    assign c_wdata = (state == S_IDLE) ? wdata_i : wdata_q;
    assign c_wr    = c_op[M_WRITE];
    assign c_rd    = c_op[M_READ] & ~c_op[M_WRITE];

    assign commit = ~rst_i & (ONE_CYC
                    ? (state == S_IDLE) & req
                    : (state == S_BUSY) & (cnt == 4'd1));

    dmem_ram #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .COMB_RD    (1'b0)
    ) u_ram (
      .clk_i  (clk_i),
      .we_i   (commit & c_wr),
      .re_i   (commit & c_rd),
      .idx_i  (c_idx),
      .wdata_i(c_wdata),
      .rdata_o(ram_q)
    );

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= S_IDLE;
      else       state <= state_nx;
    end

    // Next state: one access, then back to IDLE without re-triggering
    always_comb begin
      state_nx = state;
      unique case (state)
        S_IDLE: if (req) state_nx = S_BUSY;
        S_BUSY: if (cnt == 4'd0) state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end

    // Outputs: stall until the last cycle of the access
    always_comb begin
      stall_o = 1'b0;
      unique case (state)
        S_IDLE: stall_o = req & ~rst_i;
        S_BUSY: stall_o = (cnt != 4'd0) & ~rst_i;
        default: stall_o = 1'b0;
      endcase
    end

    // Request latches, countdown and read-data select
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cnt     <= 4'd0;
        op_q    <= '0;
        idx_q   <= '0;
        wdata_q <= 32'h0;
        sel_q   <= 1'b0;
      end else begin
        if (commit) sel_q <= c_rd;
        if (state == S_IDLE && req) begin
          op_q    <= m_in;
          idx_q   <= idx_in;
          wdata_q <= wdata_i;
          cnt     <= CNT_INIT;
        end else if (state == S_BUSY && cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end
      end
    end

    assign rdata_o = sel_q ? ram_q : 32'h0;
  end

endmodule
